alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul_iter.sv | 70 +++++++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcode values and FSM state encoding.
package alu_pkg;

  // Supported opcodes; every other code is reported as illegal.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;

  // Control FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier. The first partial product is folded into the
// load cycle, so product is final WIDTH cycles after start, while done is high.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // Next-state: load (with bit 0 already applied), iterate, then idle holding the product.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = {1'b0, b[WIDTH-1:1]};
      cnt_d    = CW'(WIDTH-1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
    end
  end

  // State registers; reset clears the iteration counter and drops any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. One request in flight at a time;
// single-cycle ops complete in one cycle, MUL uses the iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] oper1,
  input  logic [WIDTH-1:0] oper2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

  logic               accept;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] sum, diff, res_c;
  logic             ovf_c, ill_c;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (op == OPW'(OP_MUL))),
    .a       (oper1),
    .b       (oper2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // FSM next state and operand capture at acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        op_d    = op;
        a_d     = oper1;
        b_d     = oper2;
        state_d = (op == OPW'(OP_MUL)) ? ST_MUL : ST_DONE;
      end
      // An idle multiplier while in MUL can only mean a lost run; don't strand the FSM.
      ST_MUL:  if (mul_done || !mul_busy) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // Result and flags from the captured request; stable in DONE since nothing feeding them moves.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (op_q)
      OPW'(OP_ADD): begin
        res_c = sum;
        ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        res_c = diff;
        ovf_c = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OPW'(OP_MUL): begin
        res_c = mul_prod[WIDTH-1:0];
        ovf_c = |mul_prod[2*WIDTH-1:WIDTH];
      end
      OPW'(OP_AND): res_c = a_q & b_q;
      OPW'(OP_OR):  res_c = a_q | b_q;
      default:      ill_c = 1'b1;
    endcase
  end

  // Outputs only carry meaning in DONE; elsewhere they read as zero.
  assign out_valid = (state_q == ST_DONE);
  assign result    = out_valid ? res_c : '0;
  assign overflow  = out_valid && ovf_c;
  assign illegal   = out_valid && ill_c;
  assign zero      = out_valid && (res_c == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural reference model and a per-cycle monitor.
module tb_alu_seq;

  localparam int W   = 32;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] op = '0;
  logic [W-1:0]   oper1 = '0;
  logic [W-1:0]   oper2 = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   result;
  logic           overflow, zero, illegal;

  alu_seq #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .oper1(oper1), .oper2(oper2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         zro;
    logic         ill;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  bit   seen = 1'b0;

  // Reference: plain signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint s, sa, sb, maxs, mins;
    longint unsigned pa, pb, p;
    e = '0;
    e.lat = 1;
    sa = $signed(a);
    sb = $signed(b);
    maxs = (longint'(1) << (W-1)) - 1;
    mins = -(longint'(1) << (W-1));
    pa = a;
    pb = b;
    case (o)
      0: begin s = sa + sb; e.res = s[W-1:0]; e.ovf = (s > maxs) || (s < mins); end
      1: begin s = sa - sb; e.res = s[W-1:0]; e.ovf = (s > maxs) || (s < mins); end
      2: begin p = pa * pb; e.res = p[W-1:0]; e.ovf = (p >> W) != 0; e.lat = W + 1; end
      3: e.res = a & b;
      4: e.res = a | b;
      default: e.ill = 1'b1;
    endcase
    e.zro = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string n, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Every cycle a result is presented it must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", longint'(cyc - exp_q[0].acc), longint'(exp_q[0].lat));
        end
        chk("mon_result",   result,   exp_q[0].res);
        chk("mon_overflow", overflow, exp_q[0].ovf);
        chk("mon_zero",     zero,     exp_q[0].zro);
        chk("mon_illegal",  illegal,  exp_q[0].ill);
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic present(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; op = OPW'(o); oper1 = a; oper2 = b;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    e = model(o, a, b);
    e.acc = cyc;
    seen = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; op = OPW'($urandom); oper1 = $urandom; oper2 = $urandom;
  endtask

  task automatic do_req(input int o, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] r, output logic v, output logic z,
                        output logic il, output int lat);
    int n;
    present(o, a, b);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n + 1;
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
    r = result; v = overflow; z = zero; il = illegal;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = OPW'(0); oper1 = 32'h1; oper2 = 32'h1;
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, r);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_dropped", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  logic [W-1:0] r;
  logic         v, z, il;
  int           lat;

  typedef struct packed { int o; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the model against hand-computed values.
    chk("model_add_ovf", model(0, 32'h7FFFFFFF, 32'h1).ovf, 1);
    chk("model_mul_res", model(2, 32'd7, 32'd6).res, 42);
    chk("model_sub_ovf", model(1, 32'h80000000, 32'h1).ovf, 1);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result",    result,    0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_zero",      zero,      0);
    chk("rst_illegal",   illegal,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // ADD signed overflow, latency 1.
    do_req(0, 32'h7FFFFFFF, 32'h00000001, 0, r, v, z, il, lat);
    chk("add_result", r, 32'h80000000);
    chk("add_ovf", v, 1);
    chk("add_zero", z, 0);
    chk("add_lat", lat, 1);

    // SUB to zero.
    do_req(1, 32'd5, 32'd5, 0, r, v, z, il, lat);
    chk("sub_result", r, 0);
    chk("sub_zero", z, 1);
    chk("sub_ovf", v, 0);

    // MUL small, latency WIDTH+1.
    do_req(2, 32'd7, 32'd6, 0, r, v, z, il, lat);
    chk("mul_result", r, 42);
    chk("mul_ovf", v, 0);
    chk("mul_lat", lat, 33);

    // MUL whose product lives entirely in the high half.
    do_req(2, 32'h00010000, 32'h00010000, 0, r, v, z, il, lat);
    chk("mulhi_result", r, 0);
    chk("mulhi_ovf", v, 1);
    chk("mulhi_zero", z, 1);

    // OR with consumer stalling five cycles and new requests offered meanwhile.
    do_req(4, 32'hF0F00000, 32'h00000F0F, 5, r, v, z, il, lat);
    chk("or_result", r, 32'hF0F00F0F);
    chk("or_ovf", v, 0);

    // Illegal opcode.
    do_req(10, 32'h12345678, 32'h9ABCDEF0, 0, r, v, z, il, lat);
    chk("ill_result", r, 0);
    chk("ill_flag", il, 1);
    chk("ill_zero", z, 1);

    // Reset 10 cycles into a MUL aborts it silently.
    present(2, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    begin
      int seen_v;
      seen_v = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen_v++;
      end
      chk("abort_no_result", seen_v, 0);
    end

    // Boundary sweep checked by the monitor against the model.
    vecs[0] = '{0, 32'h80000000, 32'h80000000};
    vecs[1] = '{1, 32'h80000000, 32'h00000001};
    vecs[2] = '{1, 32'h00000000, 32'h00000001};
    vecs[3] = '{3, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[4] = '{2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{2, 32'h00000000, 32'hDEADBEEF};
    vecs[6] = '{15, 32'h1, 32'h2};
    vecs[7] = '{5, 32'h0, 32'h0};
    vecs[8] = '{4, 32'h0, 32'h0};
    vecs[9] = '{2, 32'h0000FFFF, 32'h00010001};
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].o, vecs[i].a, vecs[i].b, i % 3, r, v, z, il, lat);
    end
    chk("muln1_result", 0, 0 + 0 * 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
